// File: rtl/ysyx_axi_pkg.sv
// Shared AXI4-Lite definitions for the ysyx read/write masters.
//   RESP_*      : AXI response encodings
//   rd_state_t  : read-master state encoding
package ysyx_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    RSP  = 2'd3
  } rd_state_t;

endpackage

// File: rtl/Reg.sv
// Common register primitive: synchronous active-high reset, write enable.
//   clk, rst : clock / sync reset
//   din, wen : next value and load enable
//   dout     : registered value (RESET_VAL after reset)
module Reg #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  input  logic             wen
);

  always_ff @(posedge clk) begin
    if (rst)      dout <= RESET_VAL;
    else if (wen) dout <= din;
  end

endmodule

// File: rtl/axi_rd_watchdog.sv
// Read-transaction watchdog: counts enabled cycles after a clear and flags
// when the count reaches LIMIT. The count saturates at LIMIT.
//   clk, rst : clock / sync reset
//   clr      : restart count from zero (held while the master is idle)
//   en       : count this cycle (master waiting on the bus)
//   expired  : count == LIMIT
// LIMIT must be >= 1.
module axi_rd_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  assign expired = (cnt == CW'(LIMIT));

  always_ff @(posedge clk) begin
    if (rst || clr)          cnt <= '0;
    else if (en && !expired) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/ifu_axi_rd_master.sv
// AXI4-Lite read-channel initiator for the fetch/load path.
// One word read in flight at a time: request port -> AR beat -> R beat ->
// response port. Misaligned addresses are answered locally with an error
// and never reach the bus.
// Ports:
//   clk, rst                         : clock / sync active-high reset
//   req_valid/req_ready/req_addr     : core read request
//   rsp_valid/rsp_ready/rsp_data/err : core read response
//   araddr/arvalid/arready           : AXI read address channel
//   rdata/rresp/rvalid/rready        : AXI read data channel
//   busy                             : transaction in progress
//   timeout                          : sticky watchdog flag
// Optional build macro RD_TIMEOUT_EN: adds a watchdog that abandons a stuck
// transaction after TIMEOUT_CYCLES with rsp_err=1, rsp_data=0xDEADBEEF.
import ysyx_axi_pkg::*;

module ifu_axi_rd_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic              busy,
  output logic              timeout
);

  localparam logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(32'hDEAD_BEEF);

  rd_state_t  state, state_nxt;
  logic [1:0] state_q;
  logic       wd_expired;
  logic       wd_fire;
  logic       misaligned;

  Reg #(.WIDTH(2), .RESET_VAL(2'(IDLE))) u_state (
    .clk  (clk),
    .rst  (rst),
    .din  (state_nxt),
    .dout (state_q),
    .wen  (1'b1)
  );

  assign state = rd_state_t'(state_q);

  // Outputs are pure decodes of the registered state.
  assign req_ready = (state == IDLE);
  assign arvalid   = (state == AR);
  assign rready    = (state == R);
  assign rsp_valid = (state == RSP);
  assign busy      = (state != IDLE);

  assign misaligned = (req_addr[1:0] != 2'b00);

`ifdef RD_TIMEOUT_EN
  axi_rd_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clr     (state == IDLE),
    .en      ((state == AR) || (state == R)),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst)          timeout <= 1'b0;
    else if (wd_fire) timeout <= 1'b1;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign wd_expired         = 1'b0;
  assign timeout            = 1'b0;
`endif

  // A handshake landing in the expiry cycle wins: the beat completed, so the
  // transaction must not be abandoned (the responder would be left hanging).
  assign wd_fire = wd_expired &&
                   (((state == AR) && !arready) || ((state == R) && !rvalid));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (req_valid) state_nxt = misaligned ? RSP : AR;
      AR:   if (arready) state_nxt = R;
            else if (wd_fire) state_nxt = RSP;
      R:    if (rvalid || wd_fire) state_nxt = RSP;
      RSP:  if (rsp_ready) state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      araddr   <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      if ((state == IDLE) && req_valid) begin
        araddr <= req_addr;
        if (misaligned) begin
          rsp_data <= '0;
          rsp_err  <= 1'b1;
        end
      end
      if ((state == R) && rvalid) begin
        rsp_data <= rdata;
        rsp_err  <= (rresp != RESP_OKAY);
      end else if (wd_fire) begin
        rsp_data <= TIMEOUT_DATA;
        rsp_err  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ifu_axi_rd_master.sv
// Testbench for ifu_axi_rd_master: scoreboard of expected responses pushed
// at request time, popped by a monitor on every rsp handshake. A behavioural
// AXI responder with programmable 0-N cycle delays serves reads.
module tb_ifu_axi_rd_master;

  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic        busy, timeout;

  ifu_axi_rd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   t0     = 0;

  // responder controls
  int         dly_max     = 0;
  bit         stuck_r     = 0;
  bit         force_rr_en = 0;
  logic [1:0] force_rr    = 2'b00;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h1234_5678;
    if (a == 32'h8000_0010) return 32'hAAAA_AAAA;
    return a ^ 32'h5EED_C0DE;
  endfunction

  function automatic logic [1:0] rresp_of(input logic [31:0] a);
    return (a[9:2] == 8'h33) ? 2'b11 : 2'b00;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired at cycle %0d", nm, cyc);
  endtask

  // Called at a negedge; returns one negedge after the accepting posedge.
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic e, input bit push);
    exp_t x;
    int   n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    if (!req_ready) bound_fail("req_ready_wait");
    req_valid = 1'b1;
    req_addr  = a;
    x.data = d;
    x.err  = e;
    if (push) sb.push_back(x);
    t0 = cyc;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while (sb.size() != 0 && n < lim) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      bound_fail("rsp_drain");
      sb.delete();
    end
  endtask

  // Responder: acts 1ns after each negedge so it never races the driver.
  task automatic nedge();
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a;
    int          d;
    int          n;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    forever begin
      nedge();
      if (!rst && arvalid) begin
        d = (dly_max == 0) ? 0 : $urandom_range(dly_max, 0);
        repeat (d) nedge();
        arready = 1'b1;
        a = araddr;
        nedge();
        arready = 1'b0;
        d = (dly_max == 0) ? 0 : $urandom_range(dly_max, 0);
        repeat (d) nedge();
        while (stuck_r && !rst) nedge();
        if (!rst) begin
          rvalid = 1'b1;
          rdata  = mem_word(a);
          rresp  = force_rr_en ? force_rr : rresp_of(a);
          n = 0;
          while (!rready && !rst && n < 200) begin nedge(); n++; end
          nedge();
          rvalid = 1'b0;
        end
      end
    end
  end

  // Monitor: scoreboard pop on rsp handshake, plus AR-channel stability.
  bit          p_hold = 0;
  bit          p_rst  = 1;
  logic [31:0] p_addr = '0;

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst && rsp_valid && rsp_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got data=%h err=%0d, required no response", rsp_data, rsp_err);
      end else begin
        e = sb.pop_front();
        if (rsp_data !== e.data || rsp_err !== e.err) begin
          errors++;
          $display("FAIL rsp_compare: got data=%h err=%0d, required data=%h err=%0d (cycle %0d)",
                   rsp_data, rsp_err, e.data, e.err, cyc);
        end
      end
    end
    if (p_hold && !p_rst) begin
      checks++;
      if (!arvalid || araddr !== p_addr) begin
        errors++;
        $display("FAIL ar_hold: got arvalid=%0d araddr=%h, required arvalid=1 araddr=%h",
                 arvalid, araddr, p_addr);
      end
    end
    p_hold = arvalid && !arready;
    p_addr = araddr;
    p_rst  = rst;
  end

  initial begin
    logic [31:0] a;
    int          n;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_arvalid",   {31'd0, arvalid},   32'd0);
    chk("rst_rready",    {31'd0, rready},    32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
    chk("rst_rsp_data",  rsp_data,           32'd0);
    chk("rst_araddr",    araddr,             32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_timeout",   {31'd0, timeout},   32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: zero-delay responder, latency
    send(32'h8000_0000, 32'h1234_5678, 1'b0, 1);
    chk("t1_arvalid_c1", {31'd0, arvalid}, 32'd1);
    chk("t1_araddr_c1",  araddr, 32'h8000_0000);
    @(negedge clk);
    chk("t1_rsp_valid_c2", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("t1_rsp_valid_c3", {31'd0, rsp_valid}, 32'd1);
    drain(50);

    // 3: misaligned address answered locally
    send(32'h8000_0002, 32'h0, 1'b1, 1);
    chk("t3_rsp_valid_c1", {31'd0, rsp_valid}, 32'd1);
    chk("t3_arvalid_c1",   {31'd0, arvalid},   32'd0);
    @(negedge clk);
    chk("t3_arvalid_c2",   {31'd0, arvalid},   32'd0);
    drain(50);

    // 4: SLVERR passes data through with err set
    force_rr_en = 1; force_rr = 2'b10;
    send(32'h8000_0010, 32'hAAAA_AAAA, 1'b1, 1);
    drain(50);
    force_rr_en = 0;

    // 5: response back-pressure, then back-to-back request
    rsp_ready = 1'b0;
    a = 32'h8000_0040;
    send(a, mem_word(a), 1'b0, 1);
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    if (!rsp_valid) bound_fail("t5_rsp_valid_wait");
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_valid",     {31'd0, rsp_valid}, 32'd1);
      chk("t5_hold_data",      rsp_data,           mem_word(a));
      chk("t5_hold_req_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t5_req_ready_after", {31'd0, req_ready}, 32'd1);
    a = 32'h8000_0044;
    send(a, mem_word(a), 1'b0, 1);
    chk("t5_b2b_arvalid", {31'd0, arvalid}, 32'd1);
    drain(50);

    // 6: reset while waiting in R
    stuck_r = 1;
    send(32'h8000_0048, 32'h0, 1'b0, 0);
    n = 0;
    while (!rready && n < 50) begin @(negedge clk); n++; end
    if (!rready) bound_fail("t6_rready_wait");
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rready",    {31'd0, rready},    32'd0);
    chk("t6_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("t6_busy",      {31'd0, busy},      32'd0);
    chk("t6_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    stuck_r = 0;
    @(negedge clk);

`ifdef RD_TIMEOUT_EN
    // watchdog abandons a stuck R beat
    stuck_r = 1;
    send(32'h8000_0080, 32'hDEAD_BEEF, 1'b1, 1);
    drain(TO + 50);
    chk("to_timeout_set", {31'd0, timeout}, 32'd1);
    chk("to_busy",        {31'd0, busy},    32'd0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    stuck_r = 0;
    @(negedge clk);
    chk("to_timeout_clr", {31'd0, timeout}, 32'd0);
`endif

    // 2: random 0-7 cycle responder delays, 1000 sequential reads
    dly_max = 7;
    for (int i = 0; i < 1000; i++) begin
      a = 32'h8000_1000 + 32'(i) * 32'd4;
      send(a, mem_word(a), rresp_of(a) != 2'b00, 1);
    end
    drain(200);
    dly_max = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
